control_unit_team1: RTL and testbench
=====================================

Name: control_unit_team1

Overview:
Hardwired control unit that sequences the 16-bit accumulator datapath through fetch, decode, indirect and execute phases. It drives every load/increment/clear strobe, the bus-select code and the ALU/E-flag operation strobes. Its status inputs are IR, AC, E, Zero_DR and FGI. It is instantiated beside the datapath in the top level and runs from a START pulse until HLT executes.

Parameters:
DATA_W, 16, datapath word width
ADDR_W, 12, address width (IR[11:0])

Ports:
clk  in  1  system clock, rising edge
CLR_GLOBAL  in  1  asynchronous active-high reset
START  in  1  one-cycle pulse; leaves IDLE
out_IR  in  16  instruction register
out_AC  in  16  accumulator (sign and zero tests)
out_E  in  1  E flag
Zero_DR  in  1  DR==0
FGI  in  1  input flag
S  out  3  bus select: 1=AR 2=PC 3=DR 4=AC 5=IR 6=TR 7=MEM, 0=none
LD_PC, LD_AR, LD_AC, LD_DR, LD_IR, LD_OUTR, LD_TR  out  1 each  register loads
INR_PC, INR_AR, INR_AC, INR_DR, INR_TR  out  1 each  increments
RST_PC, RST_AR, RST_AC, RST_DR, RST_TR  out  1 each  register clears
AND, ADD, LDA, COM, SHL, SHR, INPR_C  out  1 each  ALU op strobes (used with LD_AC)
CLE, CME  out  1 each  clear / complement E
Read, Write  out  1 each  memory strobes, addressed by AR
SC  out  4  sequence counter T-state
RUNNING  out  1  high outside IDLE/HALT
HALTED  out  1  high after HLT

Behaviour:
- Registered state: mode {IDLE, RUN, HALT}, SC[3:0], I bit. All other outputs are combinational decode of these registers and the inputs. Outputs are 0 when mode is not RUN.
- Reset (async): mode=IDLE, SC=0, I=0. Every output is 0.
- IDLE + START: mode=RUN, SC=0 on the next edge. START is ignored in RUN and HALT; HALT exits only through CLR_GLOBAL.
- Memory read is combinational: with Read=1 and S=7, memory data is on the bus in the same cycle.
- D = decode of IR[14:12]. D7 with I=0 is register-reference; D7 with I=1 is I/O.
- Each bullet: SC value, strobes asserted that cycle.
- T0: S=2, LD_AR.
- T1: S=7, Read, LD_IR, INR_PC.
- T2: S=5, LD_AR. Latch I<=IR[15].
- T3, memory-reference with I=1: S=7, Read, LD_AR. With I=0: no strobes.
- T3, register-reference (one-hot IR[11:0]; priority LSB-first if several bits set):
  - CLA: RST_AC.
  - CLE: CLE.
  - CMA: COM, LD_AC.
  - CME: CME.
  - CIR: SHR, LD_AC.
  - CIL: SHL, LD_AC.
  - INC: INR_AC.
  - SPA: INR_PC if AC[15]==0.
  - SNA: INR_PC if AC[15]==1.
  - SZA: INR_PC if AC==0.
  - SZE: INR_PC if E==0.
  - HLT: mode<=HALT.
  - SC<=0.
- T3, I/O:
  - INP (bit11): INPR_C, LD_AC.
  - OUT (bit10): S=4, LD_OUTR.
  - SKI (bit9): INR_PC if FGI.
  - Other bits: none.
  - SC<=0.
- T4/T5/T6, memory-reference:
  - AND/ADD/LDA: T4 S=7 Read LD_DR. T5 op strobe plus LD_AC, SC<=0.
  - STA: T4 S=4 Write, SC<=0.
  - BUN: T4 S=1 LD_PC, SC<=0.
  - BSA: T4 S=2 Write INR_AR. T5 S=1 LD_PC, SC<=0.
  - ISZ: T4 S=7 Read LD_DR. T5 INR_DR. T6 S=3 Write, INR_PC if Zero_DR, SC<=0.
- Otherwise SC increments each cycle. SC never exceeds 6. An out-of-range SC forces SC<=0 (recovery).
- At most one of LD_*/INR_*/RST_* per register per cycle. Exactly one bus source.
- Reset mid-instruction aborts immediately; no partial writes after the asynchronous assertion.

Decomposition:
- Package control_pkg_team1: bus-select constants (SEL_AR..SEL_MEM), opcode constants D0..D7, register-reference and I/O bit positions, mode enum.
- Sub-module control_decode_team1: combinational 3-to-8 opcode decoder plus register-reference/I/O classification.

Test Plan:
- Reset then START with M[0]=0x2005 (LDA 5), M[5]=0x1234: AC=0x1234 after 6 RUN cycles; PC=1; SC returns 0.
- ADD indirect: M[0]=0x9006, M[6]=0x0007, M[7]=0xFFFF, AC=1: AC=0x0000, E=1; 6-cycle instruction (T0..T5).
- ISZ with M[8]=0xFFFF, M[0]=0x6008: M[8]=0x0000, PC=2 (skip); with M[8]=0x0003, PC=1.
- BSA: M[0]=0x5010: M[0x10]=0x001 (return address), PC=0x011.
- Register-reference sequence CLA, CMA, SZA, HLT: AC=0xFFFF; no skip; HALTED=1, all strobes 0; a later START is ignored.
- CLR_GLOBAL asserted at T5 of ADD: outputs drop to 0 asynchronously; mode=IDLE, SC=0; AC keeps its pre-T5 value.

Source files
------------

// File: rtl/control_pkg_team1.sv
// Shared constants for the hardwired control unit: bus codes, opcode indices,
// register-reference / I/O bit positions and the run-mode encoding.
package control_pkg_team1;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_AR   = 3'd1;
    localparam logic [2:0] SEL_PC   = 3'd2;
    localparam logic [2:0] SEL_DR   = 3'd3;
    localparam logic [2:0] SEL_AC   = 3'd4;
    localparam logic [2:0] SEL_IR   = 3'd5;
    localparam logic [2:0] SEL_TR   = 3'd6;
    localparam logic [2:0] SEL_MEM  = 3'd7;

    localparam logic [2:0] D0 = 3'd0;  // AND
    localparam logic [2:0] D1 = 3'd1;  // ADD
    localparam logic [2:0] D2 = 3'd2;  // LDA
    localparam logic [2:0] D3 = 3'd3;  // STA
    localparam logic [2:0] D4 = 3'd4;  // BUN
    localparam logic [2:0] D5 = 3'd5;  // BSA
    localparam logic [2:0] D6 = 3'd6;  // ISZ
    localparam logic [2:0] D7 = 3'd7;  // register-reference / I/O

    localparam int RR_CLA = 11;
    localparam int RR_CLE = 10;
    localparam int RR_CMA = 9;
    localparam int RR_CME = 8;
    localparam int RR_CIR = 7;
    localparam int RR_CIL = 6;
    localparam int RR_INC = 5;
    localparam int RR_SPA = 4;
    localparam int RR_SNA = 3;
    localparam int RR_SZA = 2;
    localparam int RR_SZE = 1;
    localparam int RR_HLT = 0;

    localparam int IO_INP = 11;
    localparam int IO_OUT = 10;
    localparam int IO_SKI = 9;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_HALT = 2'd2
    } mode_t;

    // Keeps only the lowest set bit, so multi-bit register-reference words
    // resolve LSB-first.
    function automatic logic [ADDR_W-1:0] lsb_first(input logic [ADDR_W-1:0] v);
        return v & (~v + ADDR_W'(1));
    endfunction

endpackage

// File: rtl/control_decode_team1.sv
// Opcode decoder: one-hot D0..D7 plus register-reference / I/O classification
// with a single selected operation per instruction word.
module control_decode_team1
    import control_pkg_team1::*;
(
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] ir_low,
    input  logic              i_bit,
    output logic [7:0]        d,
    output logic              reg_ref,
    output logic              io,
    output logic [ADDR_W-1:0] rr,
    output logic              io_inp,
    output logic              io_out,
    output logic              io_ski
);

    always_comb begin
        d       = 8'b1 << opcode;
        reg_ref = d[D7] & ~i_bit;
        io      = d[D7] & i_bit;
        rr      = reg_ref ? lsb_first(ir_low) : '0;
        // Only the three defined I/O bits are considered, lowest first.
        io_ski  = io & ir_low[IO_SKI];
        io_out  = io & ir_low[IO_OUT] & ~ir_low[IO_SKI];
        io_inp  = io & ir_low[IO_INP] & ~ir_low[IO_OUT] & ~ir_low[IO_SKI];
    end

endmodule

// File: rtl/control_unit_team1.sv
// Hardwired control unit for the 16-bit accumulator machine: sequences fetch,
// decode, indirect and execute T-states and drives all datapath strobes.
module control_unit_team1
    import control_pkg_team1::*;
(
    input  logic              clk,
    input  logic              CLR_GLOBAL,
    input  logic              START,
    input  logic [DATA_W-1:0] out_IR,
    input  logic [DATA_W-1:0] out_AC,
    input  logic              out_E,
    input  logic              Zero_DR,
    input  logic              FGI,
    output logic [2:0]        S,
    output logic              LD_PC,
    output logic              LD_AR,
    output logic              LD_AC,
    output logic              LD_DR,
    output logic              LD_IR,
    output logic              LD_OUTR,
    output logic              LD_TR,
    output logic              INR_PC,
    output logic              INR_AR,
    output logic              INR_AC,
    output logic              INR_DR,
    output logic              INR_TR,
    output logic              RST_PC,
    output logic              RST_AR,
    output logic              RST_AC,
    output logic              RST_DR,
    output logic              RST_TR,
    output logic              AND,
    output logic              ADD,
    output logic              LDA,
    output logic              COM,
    output logic              SHL,
    output logic              SHR,
    output logic              INPR_C,
    output logic              CLE,
    output logic              CME,
    output logic              Read,
    output logic              Write,
    output logic [3:0]        SC,
    output logic              RUNNING,
    output logic              HALTED
);

    mode_t             mode, mode_next;
    logic [3:0]        sc_next;
    logic              i_bit, i_next;
    logic [7:0]        d;
    logic              reg_ref, io;
    logic [ADDR_W-1:0] rr;
    logic              io_inp, io_out, io_ski;
    logic              ac_zero;

    control_decode_team1 u_decode (
        .opcode  (out_IR[14:12]),
        .ir_low  (out_IR[ADDR_W-1:0]),
        .i_bit   (i_bit),
        .d       (d),
        .reg_ref (reg_ref),
        .io      (io),
        .rr      (rr),
        .io_inp  (io_inp),
        .io_out  (io_out),
        .io_ski  (io_ski)
    );

    assign ac_zero = (out_AC == '0);
    assign RUNNING = (mode == MODE_RUN);
    assign HALTED  = (mode == MODE_HALT);

    always_ff @(posedge clk or posedge CLR_GLOBAL) begin
        if (CLR_GLOBAL) begin
            mode  <= MODE_IDLE;
            SC    <= 4'd0;
            i_bit <= 1'b0;
        end else begin
            mode  <= mode_next;
            SC    <= sc_next;
            i_bit <= i_next;
        end
    end

    always_comb begin
        mode_next = mode;
        sc_next   = 4'd0;
        i_next    = i_bit;
        case (mode)
            MODE_IDLE: if (START) mode_next = MODE_RUN;
            MODE_RUN: begin
                sc_next = SC + 4'd1;
                case (SC)
                    4'd2: i_next = out_IR[DATA_W-1];
                    4'd3: begin
                        if (d[D7]) begin
                            sc_next = 4'd0;
                            if (rr[RR_HLT]) mode_next = MODE_HALT;
                        end
                    end
                    4'd4: if (d[D3] | d[D4]) sc_next = 4'd0;
                    4'd5: if (d[D0] | d[D1] | d[D2] | d[D5]) sc_next = 4'd0;
                    4'd6: sc_next = 4'd0;
                    default: if (SC > 4'd6) sc_next = 4'd0;  // recovery
                endcase
            end
            MODE_HALT: mode_next = MODE_HALT;
            default:   mode_next = MODE_IDLE;
        endcase
    end

    always_comb begin
        S       = SEL_NONE;
        LD_PC   = 1'b0;
        LD_AR   = 1'b0;
        LD_AC   = 1'b0;
        LD_DR   = 1'b0;
        LD_IR   = 1'b0;
        LD_OUTR = 1'b0;
        LD_TR   = 1'b0;
        INR_PC  = 1'b0;
        INR_AR  = 1'b0;
        INR_AC  = 1'b0;
        INR_DR  = 1'b0;
        INR_TR  = 1'b0;
        RST_PC  = 1'b0;
        RST_AR  = 1'b0;
        RST_AC  = 1'b0;
        RST_DR  = 1'b0;
        RST_TR  = 1'b0;
        AND     = 1'b0;
        ADD     = 1'b0;
        LDA     = 1'b0;
        COM     = 1'b0;
        SHL     = 1'b0;
        SHR     = 1'b0;
        INPR_C  = 1'b0;
        CLE     = 1'b0;
        CME     = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        if (mode == MODE_RUN) begin
            case (SC)
                4'd0: begin
                    S     = SEL_PC;
                    LD_AR = 1'b1;
                end
                4'd1: begin
                    S      = SEL_MEM;
                    Read   = 1'b1;
                    LD_IR  = 1'b1;
                    INR_PC = 1'b1;
                end
                4'd2: begin
                    S     = SEL_IR;
                    LD_AR = 1'b1;
                end
                4'd3: begin
                    if (reg_ref) begin
                        RST_AC = rr[RR_CLA];
                        CLE    = rr[RR_CLE];
                        COM    = rr[RR_CMA];
                        CME    = rr[RR_CME];
                        SHR    = rr[RR_CIR];
                        SHL    = rr[RR_CIL];
                        INR_AC = rr[RR_INC];
                        LD_AC  = rr[RR_CMA] | rr[RR_CIR] | rr[RR_CIL];
                        INR_PC = (rr[RR_SPA] & ~out_AC[DATA_W-1]) |
                                 (rr[RR_SNA] &  out_AC[DATA_W-1]) |
                                 (rr[RR_SZA] &  ac_zero) |
                                 (rr[RR_SZE] & ~out_E);
                    end else if (io) begin
                        INPR_C  = io_inp;
                        LD_AC   = io_inp;
                        LD_OUTR = io_out;
                        INR_PC  = io_ski & FGI;
                        if (io_out) S = SEL_AC;
                    end else if (i_bit) begin
                        S     = SEL_MEM;
                        Read  = 1'b1;
                        LD_AR = 1'b1;
                    end
                end
                4'd4: begin
                    if (d[D0] | d[D1] | d[D2] | d[D6]) begin
                        S     = SEL_MEM;
                        Read  = 1'b1;
                        LD_DR = 1'b1;
                    end else if (d[D3]) begin
                        S     = SEL_AC;
                        Write = 1'b1;
                    end else if (d[D4]) begin
                        S     = SEL_AR;
                        LD_PC = 1'b1;
                    end else if (d[D5]) begin
                        S      = SEL_PC;
                        Write  = 1'b1;
                        INR_AR = 1'b1;
                    end
                end
                4'd5: begin
                    AND    = d[D0];
                    ADD    = d[D1];
                    LDA    = d[D2];
                    LD_AC  = d[D0] | d[D1] | d[D2];
                    INR_DR = d[D6];
                    if (d[D5]) begin
                        S     = SEL_AR;
                        LD_PC = 1'b1;
                    end
                end
                4'd6: begin
                    if (d[D6]) begin
                        S      = SEL_DR;
                        Write  = 1'b1;
                        INR_PC = Zero_DR;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit_team1.sv
// Bench for control_unit_team1: a small datapath/memory model reacts to the
// strobes while a monitor compares every RUN cycle against a directed queue.
module tb_control_unit_team1;

    logic        clk = 1'b0;
    logic        CLR_GLOBAL, START, FGI;
    logic [15:0] out_IR, out_AC;
    logic        out_E, Zero_DR;
    logic [2:0]  S;
    logic        LD_PC, LD_AR, LD_AC, LD_DR, LD_IR, LD_OUTR, LD_TR;
    logic        INR_PC, INR_AR, INR_AC, INR_DR, INR_TR;
    logic        RST_PC, RST_AR, RST_AC, RST_DR, RST_TR;
    logic        AND, ADD, LDA, COM, SHL, SHR, INPR_C, CLE, CME, Read, Write;
    logic [3:0]  SC;
    logic        RUNNING, HALTED;

    // Strobe masks: bit positions of the packed control word below.
    localparam logic [27:0] M_NONE    = 28'h0000000;
    localparam logic [27:0] M_LD_PC   = 28'h0000001;
    localparam logic [27:0] M_LD_AR   = 28'h0000002;
    localparam logic [27:0] M_LD_AC   = 28'h0000004;
    localparam logic [27:0] M_LD_DR   = 28'h0000008;
    localparam logic [27:0] M_LD_IR   = 28'h0000010;
    localparam logic [27:0] M_LD_OUTR = 28'h0000020;
    localparam logic [27:0] M_INR_PC  = 28'h0000080;
    localparam logic [27:0] M_INR_AR  = 28'h0000100;
    localparam logic [27:0] M_INR_DR  = 28'h0000400;
    localparam logic [27:0] M_RST_AC  = 28'h0004000;
    localparam logic [27:0] M_ADD     = 28'h0040000;
    localparam logic [27:0] M_LDA     = 28'h0080000;
    localparam logic [27:0] M_COM     = 28'h0100000;
    localparam logic [27:0] M_READ    = 28'h4000000;
    localparam logic [27:0] M_WRITE   = 28'h8000000;

    logic [27:0] strobes;
    logic [34:0] act;
    logic [34:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    assign strobes = {Write, Read, CME, CLE, INPR_C, SHR, SHL, COM, LDA, ADD, AND,
                      RST_TR, RST_DR, RST_AC, RST_AR, RST_PC,
                      INR_TR, INR_DR, INR_AC, INR_AR, INR_PC,
                      LD_TR, LD_OUTR, LD_IR, LD_DR, LD_AC, LD_AR, LD_PC};
    assign act = {SC, S, strobes};

    control_unit_team1 dut (
        .clk(clk), .CLR_GLOBAL(CLR_GLOBAL), .START(START),
        .out_IR(out_IR), .out_AC(out_AC), .out_E(out_E), .Zero_DR(Zero_DR), .FGI(FGI),
        .S(S), .LD_PC(LD_PC), .LD_AR(LD_AR), .LD_AC(LD_AC), .LD_DR(LD_DR), .LD_IR(LD_IR),
        .LD_OUTR(LD_OUTR), .LD_TR(LD_TR), .INR_PC(INR_PC), .INR_AR(INR_AR), .INR_AC(INR_AC),
        .INR_DR(INR_DR), .INR_TR(INR_TR), .RST_PC(RST_PC), .RST_AR(RST_AR), .RST_AC(RST_AC),
        .RST_DR(RST_DR), .RST_TR(RST_TR), .AND(AND), .ADD(ADD), .LDA(LDA), .COM(COM),
        .SHL(SHL), .SHR(SHR), .INPR_C(INPR_C), .CLE(CLE), .CME(CME), .Read(Read),
        .Write(Write), .SC(SC), .RUNNING(RUNNING), .HALTED(HALTED)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- datapath / memory model ----------------
    logic [15:0] mem [0:4095];
    logic [15:0] prog_mem [0:4095];
    logic [11:0] ar, pc;
    logic [15:0] ac, dr, ir, tr, bus;
    logic [7:0]  outr;
    logic        e;
    logic        init_req = 1'b0;
    logic [15:0] init_ac;
    logic        init_e;

    assign out_IR  = ir;
    assign out_AC  = ac;
    assign out_E   = e;
    assign Zero_DR = (dr == 16'h0000);

    always_comb begin
        bus = 16'h0000;
        case (S)
            3'd1: bus = {4'h0, ar};
            3'd2: bus = {4'h0, pc};
            3'd3: bus = dr;
            3'd4: bus = ac;
            3'd5: bus = ir;
            3'd6: bus = tr;
            3'd7: bus = mem[ar];
            default: bus = 16'h0000;
        endcase
    end

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 4096; i++) mem[i] <= prog_mem[i];
            ar <= 12'h000; pc <= 12'h000; dr <= 16'h0000; ir <= 16'h0000;
            tr <= 16'h0000; outr <= 8'h00; ac <= init_ac; e <= init_e;
        end else begin
            if (LD_AR) ar <= bus[11:0]; else if (INR_AR) ar <= ar + 12'd1; else if (RST_AR) ar <= 12'h000;
            if (LD_PC) pc <= bus[11:0]; else if (INR_PC) pc <= pc + 12'd1; else if (RST_PC) pc <= 12'h000;
            if (LD_DR) dr <= bus; else if (INR_DR) dr <= dr + 16'd1; else if (RST_DR) dr <= 16'h0000;
            if (LD_TR) tr <= bus; else if (INR_TR) tr <= tr + 16'd1; else if (RST_TR) tr <= 16'h0000;
            if (LD_IR) ir <= bus;
            if (LD_OUTR) outr <= bus[7:0];
            if (LD_AC) begin
                if (AND) ac <= ac & dr;
                else if (ADD) {e, ac} <= {1'b0, ac} + {1'b0, dr};
                else if (LDA) ac <= dr;
                else if (COM) ac <= ~ac;
                else if (SHR) {ac, e} <= {e, ac};
                else if (SHL) {e, ac} <= {ac, e};
                else if (INPR_C) ac[7:0] <= 8'h5A;
                else ac <= bus;
            end else if (INR_AC) ac <= ac + 16'd1;
            else if (RST_AC) ac <= 16'h0000;
            if (CLE) e <= 1'b0; else if (CME) e <= ~e;
            if (Write) mem[ar] <= bus;
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic push(input logic [3:0] sc, input logic [2:0] sel, input logic [27:0] m);
        exp_q.push_back({sc, sel, m});
    endtask

    task automatic push_fetch();
        push(4'd0, 3'd2, M_LD_AR);
        push(4'd1, 3'd7, M_READ | M_LD_IR | M_INR_PC);
        push(4'd2, 3'd5, M_LD_AR);
    endtask

    // Monitor: every RUN cycle must match the next queued control word.
    task automatic monitor();
        logic [34:0] w;
        forever begin
            @(negedge clk);
            if (RUNNING) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL ctrl_unexpected: got %h required no RUN cycle", act);
                end else begin
                    w = exp_q.pop_front();
                    if (act !== w) begin
                        errors++;
                        $display("FAIL ctrl_t%0d: got %h required %h", w[34:31], act, w);
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_prog();
        for (int i = 0; i < 4096; i++) prog_mem[i] = 16'h0000;
    endtask

    task automatic prep(input logic [15:0] a, input logic ev);
        init_ac    = a;
        init_e     = ev;
        init_req   = 1'b1;
        CLR_GLOBAL = 1'b1;
        @(posedge clk); #1;
        init_req   = 1'b0;
        CLR_GLOBAL = 1'b0;
    endtask

    task automatic start_pulse();
        START = 1'b1;
        @(posedge clk); #1;
        START = 1'b0;
    endtask

    task automatic run_to_halt(input string name);
        int n = 0;
        start_pulse();
        while (!HALTED && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_halted"}, 64'(HALTED), 64'd1);
        @(negedge clk); #1;
        chk({name, "_q_drained"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        chk({name, "_halt_ctrl"}, 64'(act), 64'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        CLR_GLOBAL = 1'b1;
        START      = 1'b0;
        FGI        = 1'b0;
        init_ac    = 16'h0000;
        init_e     = 1'b0;
        clear_prog();
        fork monitor(); join_none
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", 64'(act), 64'd0);
        chk("reset_running", 64'(RUNNING), 64'd0);
        chk("reset_halted", 64'(HALTED), 64'd0);
        CLR_GLOBAL = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_no_start", 64'(RUNNING), 64'd0);

        // LDA 5 then HLT
        clear_prog();
        prog_mem[0] = 16'h2005; prog_mem[5] = 16'h1234; prog_mem[1] = 16'h7001;
        prep(16'h0000, 1'b0);
        push_fetch(); push(4'd3, 3'd0, M_NONE); push(4'd4, 3'd7, M_READ | M_LD_DR);
        push(4'd5, 3'd0, M_LDA | M_LD_AC);
        push_fetch(); push(4'd3, 3'd0, M_NONE);
        run_to_halt("lda");
        chk("lda_ac", 64'(ac), 64'h1234);
        chk("lda_pc_after_hlt", 64'(pc), 64'd2);
        chk("lda_sc", 64'(SC), 64'd0);

        // ADD indirect: 1 + 0xFFFF carries into E
        clear_prog();
        prog_mem[0] = 16'h9006; prog_mem[6] = 16'h0007; prog_mem[7] = 16'hFFFF; prog_mem[1] = 16'h7001;
        prep(16'h0001, 1'b0);
        push_fetch(); push(4'd3, 3'd7, M_READ | M_LD_AR); push(4'd4, 3'd7, M_READ | M_LD_DR);
        push(4'd5, 3'd0, M_ADD | M_LD_AC);
        push_fetch(); push(4'd3, 3'd0, M_NONE);
        run_to_halt("add_ind");
        chk("add_ac", 64'(ac), 64'h0000);
        chk("add_e", 64'(e), 64'd1);

        // ISZ reaching zero skips
        clear_prog();
        prog_mem[0] = 16'h6008; prog_mem[8] = 16'hFFFF; prog_mem[2] = 16'h7001;
        prep(16'h0000, 1'b0);
        push_fetch(); push(4'd3, 3'd0, M_NONE); push(4'd4, 3'd7, M_READ | M_LD_DR);
        push(4'd5, 3'd0, M_INR_DR); push(4'd6, 3'd3, M_WRITE | M_INR_PC);
        push_fetch(); push(4'd3, 3'd0, M_NONE);
        run_to_halt("isz_skip");
        chk("isz_skip_mem", 64'(mem[8]), 64'h0000);
        chk("isz_skip_pc", 64'(pc), 64'd3);

        // ISZ not reaching zero
        clear_prog();
        prog_mem[0] = 16'h6008; prog_mem[8] = 16'h0003; prog_mem[1] = 16'h7001;
        prep(16'h0000, 1'b0);
        push_fetch(); push(4'd3, 3'd0, M_NONE); push(4'd4, 3'd7, M_READ | M_LD_DR);
        push(4'd5, 3'd0, M_INR_DR); push(4'd6, 3'd3, M_WRITE);
        push_fetch(); push(4'd3, 3'd0, M_NONE);
        run_to_halt("isz_noskip");
        chk("isz_noskip_mem", 64'(mem[8]), 64'h0004);
        chk("isz_noskip_pc", 64'(pc), 64'd2);

        // BSA 0x010: return address stored, jump to 0x011
        clear_prog();
        prog_mem[0] = 16'h5010; prog_mem[17] = 16'h7001;
        prep(16'h0000, 1'b0);
        push_fetch(); push(4'd3, 3'd0, M_NONE); push(4'd4, 3'd2, M_WRITE | M_INR_AR);
        push(4'd5, 3'd1, M_LD_PC);
        push_fetch(); push(4'd3, 3'd0, M_NONE);
        run_to_halt("bsa");
        chk("bsa_ret_addr", 64'(mem[16]), 64'h0001);
        chk("bsa_pc", 64'(pc), 64'h012);

        // CLA, CMA, SZA (no skip), HLT; START afterwards is ignored
        clear_prog();
        prog_mem[0] = 16'h7800; prog_mem[1] = 16'h7200; prog_mem[2] = 16'h7004; prog_mem[3] = 16'h7001;
        prep(16'h1234, 1'b0);
        push_fetch(); push(4'd3, 3'd0, M_RST_AC);
        push_fetch(); push(4'd3, 3'd0, M_COM | M_LD_AC);
        push_fetch(); push(4'd3, 3'd0, M_NONE);
        push_fetch(); push(4'd3, 3'd0, M_NONE);
        run_to_halt("regref");
        chk("regref_ac", 64'(ac), 64'hFFFF);
        chk("regref_pc", 64'(pc), 64'd4);
        start_pulse();
        repeat (3) @(posedge clk);
        #1;
        chk("halt_start_ignored", 64'(HALTED), 64'd1);
        chk("halt_not_running", 64'(RUNNING), 64'd0);
        chk("halt_ctrl_zero", 64'(act), 64'd0);

        // OUT, SKI with FGI=1, then SZE|HLT where HLT (bit 0) wins
        clear_prog();
        prog_mem[0] = 16'hF400; prog_mem[1] = 16'hF200; prog_mem[3] = 16'h7003;
        prep(16'hABCD, 1'b0);
        FGI = 1'b1;
        push_fetch(); push(4'd3, 3'd4, M_LD_OUTR);
        push_fetch(); push(4'd3, 3'd0, M_INR_PC);
        push_fetch(); push(4'd3, 3'd0, M_NONE);
        run_to_halt("io");
        FGI = 1'b0;
        chk("io_outr", 64'(outr), 64'hCD);
        chk("io_pc", 64'(pc), 64'd4);

        // Reset during T5 of ADD indirect aborts before the AC load
        clear_prog();
        prog_mem[0] = 16'h9006; prog_mem[6] = 16'h0007; prog_mem[7] = 16'hFFFF; prog_mem[1] = 16'h7001;
        prep(16'h0001, 1'b0);
        push_fetch(); push(4'd3, 3'd7, M_READ | M_LD_AR); push(4'd4, 3'd7, M_READ | M_LD_DR);
        start_pulse();
        begin
            int n = 0;
            while (SC != 4'd5 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("abort_reached_t5", 64'(SC), 64'd5);
        CLR_GLOBAL = 1'b1;
        #1;
        chk("abort_ctrl_zero", 64'(act), 64'd0);
        chk("abort_running", 64'(RUNNING), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_ac_kept", 64'(ac), 64'h0001);
        chk("abort_q_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        CLR_GLOBAL = 1'b0;

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
